// File: rtl/wcoder_pkg.sv
// wcoder_pkg: shared types and constants for the wcoder DPCM pixel encoder.
// Optional feature macro used by the design: WCODER_LINE_CHECKSUM_EN.
`timescale 1ns/1ps

package wcoder_pkg;

    localparam int PIX_W              = 8;
    localparam int DEFAULT_FIFO_DEPTH = 16;
    localparam int LINE_CNT_W         = 16;

    typedef logic [PIX_W-1:0] code_t;

    // Per-line encoder context. The count saturates; it only needs to tell
    // "line has at least one pixel" apart from "line is empty".
    typedef struct packed {
        code_t                 predictor;
        logic                  first;
        logic [LINE_CNT_W-1:0] count;
        code_t                 checksum;
    } line_state_t;

    // Context after reset or vsync: zero predictor, next pixel is sent raw.
    localparam line_state_t LINE_RESET = '{
        predictor: '0,
        first:     1'b1,
        count:     '0,
        checksum:  '0
    };

    // DPCM code: raw pixel at the start of a line, otherwise the mod-256
    // difference from the previous pixel.
    function automatic code_t dpcm_code(input code_t pix, input code_t pred,
                                        input logic first);
        code_t diff;
        diff = pix - pred;
        return first ? pix : diff;
    endfunction

endpackage

// File: rtl/wcoder_fifo.sv
// wcoder_fifo: synchronous byte FIFO with a registered head byte and a
// registered non-empty flag. Head and flag lag the storage by one edge, so a
// push into an empty FIFO shows up one edge after it is written, and the byte
// behind a popped head shows up one edge after the pop.
`timescale 1ns/1ps

module wcoder_fifo
    import wcoder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  code_t wdata,
    input  logic  pop,
    output logic  full,
    output logic  empty,
    output logic  head_vld,
    output code_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    code_t         mem_q [DEPTH];
    code_t         mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    code_t         head_q, head_d;
    logic          head_vld_q, head_vld_d;
    logic          do_push, do_pop;

    assign full     = (cnt_q == CNT_FULL);
    assign empty    = (cnt_q == '0);
    assign head     = head_q;
    assign head_vld = head_vld_q;

    // Next-state for storage, pointers, occupancy and the registered head.
    // A push into a full FIFO is dropped; a pop of an empty FIFO is ignored.
    always_comb begin
        do_pop     = pop && (cnt_q != '0);
        do_push    = push && (cnt_q != CNT_FULL);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        // Head holds its last byte once the FIFO runs dry.
        head_vld_d = (cnt_q != '0);
        head_d     = head_vld_d ? mem_q[rd_ptr_q] : head_q;
    end

    // Control and head registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
        end
    end

    // Storage array; contents are only read while the count says they are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/wcoder.sv
// wcoder: DPCM pixel-stream encoder feeding a byte FIFO drained by a strobe.
// Build option: define WCODER_LINE_CHECKSUM_EN to append a mod-256 sum of each
// non-empty line's raw pixels after that line's last code.
`timescale 1ns/1ps

module wcoder
    import wcoder_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic             pclk,
    input  logic             vsync,
    input  logic             hsync,
    input  logic [PIX_W-1:0] din,
    output logic             ready,
    input  logic             dclk,
    output logic [PIX_W-1:0] dout,
    input  logic             rst_n
);

    localparam logic [LINE_CNT_W-1:0] CNT_ONE = LINE_CNT_W'(1);

    line_state_t line_q, line_d;
    code_t       code_q, code_d;
    logic        code_vld_q, code_vld_d;
    logic        dclk_q, dclk_d;
    logic        pop_req;
    logic        fifo_full, fifo_empty;

    // Sync decode and DPCM stage. Any cycle with a sync high is a marker, never
    // a pixel; repeated marker cycles leave the already-cleared state alone.
    always_comb begin
        line_d     = line_q;
        code_d     = code_q;
        code_vld_d = 1'b0;
        if (vsync) begin
            line_d = LINE_RESET;
        end else if (hsync) begin
            line_d.first    = 1'b1;
            line_d.count    = '0;
            line_d.checksum = '0;
        end else begin
            code_d           = dpcm_code(din, line_q.predictor, line_q.first);
            code_vld_d       = 1'b1;
            line_d.predictor = din;
            line_d.first     = 1'b0;
            if (line_q.count != '1) begin
                line_d.count = line_q.count + CNT_ONE;
            end
`ifdef WCODER_LINE_CHECKSUM_EN
            line_d.checksum = line_q.checksum + din;
`endif
        end
`ifdef WCODER_LINE_CHECKSUM_EN
        // Only the first marker cycle after a non-empty line sees count != 0,
        // so the trailer is emitted exactly once per line.
        if ((vsync || hsync) && (line_q.count != '0)) begin
            code_d     = line_q.checksum;
            code_vld_d = 1'b1;
        end
`endif
    end

    // Consumer handshake: ready=1 means dout holds a valid byte; a rising edge
    // of dclk seen at a pclk edge while ready=1 pops that byte. Edges seen
    // while ready=0 are discarded, not queued.
    always_comb begin
        dclk_d  = dclk;
        pop_req = dclk && !dclk_q && ready && !fifo_empty;
    end

    // Encoder pipeline registers and the dclk history bit.
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            line_q     <= LINE_RESET;
            code_q     <= '0;
            code_vld_q <= 1'b0;
            dclk_q     <= 1'b0;
        end else begin
            line_q     <= line_d;
            code_q     <= code_d;
            code_vld_q <= code_vld_d;
            dclk_q     <= dclk_d;
        end
    end

    wcoder_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (pclk),
        .rst_n    (rst_n),
        .push     (code_vld_q && !fifo_full),
        .wdata    (code_q),
        .pop      (pop_req),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_vld (ready),
        .head     (dout)
    );

endmodule

// File: tb/tb_wcoder.sv
// tb_wcoder: directed and randomized stimulus for wcoder, checked against a
// line-based reference model (expected byte queue) kept in the bench.
`timescale 1ns/1ps

module tb_wcoder;

    localparam int DEPTH = 16;
`ifdef WCODER_LINE_CHECKSUM_EN
    localparam int FRAME_BYTES = 49;
`else
    localparam int FRAME_BYTES = 42;
`endif

    // ---------------- clock / reset ----------------
    logic       pclk = 1'b0;
    logic       rst_n;
    logic       vsync;
    logic       hsync;
    logic [7:0] din;
    logic       ready;
    logic       dclk;
    logic [7:0] dout;

    always #5 pclk = ~pclk;

    wcoder #(.FIFO_DEPTH(DEPTH)) dut (
        .pclk  (pclk),
        .vsync (vsync),
        .hsync (hsync),
        .din   (din),
        .ready (ready),
        .dclk  (dclk),
        .dout  (dout),
        .rst_n (rst_n)
    );

    // ---------------- scoreboard state ----------------
    int         n_vec = 0;
    int         n_err = 0;
    int         n_pop = 0;
    logic [7:0] exp_q[$];
    logic [7:0] line_q[$];
    logic [7:0] last_pop = 8'd0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    // Bytes reach the buffer in arrival order; once it holds DEPTH bytes that
    // nobody has read, further bytes are lost.
    function automatic void push_code(input logic [7:0] c);
        if (exp_q.size() < DEPTH) exp_q.push_back(c);
    endfunction

    // A line is the list of raw pixels since the last marker. Code i is pixel i
    // minus pixel i-1 (mod 256), with pixel 0 sent as is.
    function automatic void model_step(input logic v, input logic h, input logic [7:0] d);
        logic [7:0] diff;
        if (v || h) begin
`ifdef WCODER_LINE_CHECKSUM_EN
            if (line_q.size() != 0) begin
                logic [7:0] s;
                s = 8'd0;
                foreach (line_q[i]) s = s + line_q[i];
                push_code(s);
            end
`endif
            line_q.delete();
        end else begin
            if (line_q.size() == 0) begin
                push_code(d);
            end else begin
                diff = d - line_q[line_q.size()-1];
                push_code(diff);
            end
            line_q.push_back(d);
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) begin
            check({tag, "_extra_byte"}, 8'(ready), 8'd0);
        end else begin
            check(tag, dout, exp_q[0]);
            void'(exp_q.pop_front());
        end
        last_pop = dout;
        n_pop++;
    endtask

    // One pclk cycle. With toggle set, dclk flips; a low-to-high flip while
    // ready is observed high is a pop, so the head is checked right then.
    task automatic run_cycle(input logic v, input logic h, input logic [7:0] d,
                             input bit toggle, input string tag);
        vsync = v;
        hsync = h;
        din   = d;
        if (toggle) begin
            if (dclk == 1'b0) begin
                if (ready === 1'b1) pop_check(tag);
                dclk = 1'b1;
            end else begin
                dclk = 1'b0;
            end
        end
        model_step(v, h, d);
        @(posedge pclk);
        #1;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b1, 8'd0, 1'b0, tag);
    endtask

    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || ready === 1'b1) && cyc < 200) begin
            run_cycle(1'b0, 1'b1, 8'd0, 1'b1, tag);
            cyc++;
        end
        check({tag, "_timeout"}, 8'(cyc >= 200), 8'd0);
        if (dclk) run_cycle(1'b0, 1'b1, 8'd0, 1'b1, tag);
        idle(2, tag);
        check({tag, "_ready_low"}, 8'(ready), 8'd0);
        check({tag, "_dout_hold"}, dout, last_pop);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int base;
        int gap;
        int len;
        bit use_v;

        rst_n = 1'b0;
        vsync = 1'b0;
        hsync = 1'b0;
        din   = 8'd0;
        dclk  = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        check("reset_ready", 8'(ready), 8'd0);
        check("reset_dout", dout, 8'd0);
        rst_n = 1'b1;

        // Frame of 7 lines, line k = k+1 .. k+6, drained while streaming.
        base = n_pop;
        run_cycle(1'b1, 1'b0, 8'd0, 1'b1, "frame");
        for (int k = 0; k < 7; k++) begin
            for (int g = 0; g < 6; g++) run_cycle(1'b0, 1'b1, 8'd0, 1'b1, "frame");
            for (int p = 0; p < 6; p++) run_cycle(1'b0, 1'b0, 8'(k + 1 + p), 1'b1, "frame");
        end
        drain("frame");
        check("frame_count", 8'(n_pop - base), 8'(FRAME_BYTES));

        // Mod-256 wrap in both directions.
        run_cycle(1'b0, 1'b1, 8'd0, 1'b0, "wrap");
        run_cycle(1'b0, 1'b0, 8'd250, 1'b0, "wrap");
        run_cycle(1'b0, 1'b0, 8'd3, 1'b0, "wrap");
        run_cycle(1'b0, 1'b1, 8'd0, 1'b0, "wrap");
        run_cycle(1'b0, 1'b0, 8'd3, 1'b0, "wrap");
        run_cycle(1'b0, 1'b0, 8'd250, 1'b0, "wrap");
        idle(3, "wrap");
        drain("wrap");

        // Overflow: 20 pixels with no reads, only DEPTH bytes survive.
        base = n_pop;
        run_cycle(1'b0, 1'b1, 8'd0, 1'b0, "ovf");
        for (int p = 1; p <= 20; p++) run_cycle(1'b0, 1'b0, 8'(p), 1'b0, "ovf");
        idle(4, "ovf");
        check("ovf_ready", 8'(ready), 8'd1);
        drain("ovf");
        check("ovf_count", 8'(n_pop - base), 8'(DEPTH));

        // dclk edges while empty must not be remembered.
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b1, 8'd0, 1'b1, "empty_edge");
        run_cycle(1'b0, 1'b0, 8'd99, 1'b0, "empty_edge");
        idle(3, "empty_edge");
        check("empty_edge_ready", 8'(ready), 8'd1);
        check("empty_edge_dout", dout, 8'd99);
        drain("empty_edge");

        // Random lines with concurrent drain; some markers are vsync-only.
        for (int l = 0; l < 12; l++) begin
            len   = $urandom_range(1, 8);
            gap   = len + $urandom_range(2, 4);
            use_v = ($urandom_range(0, 3) == 0);
            for (int g = 0; g < gap; g++) run_cycle(use_v, !use_v, 8'd0, 1'b1, "rand");
            for (int p = 0; p < len; p++) run_cycle(1'b0, 1'b0, 8'($urandom), 1'b1, "rand");
        end
        drain("rand");

        // Mid-line reset with bytes buffered.
        run_cycle(1'b0, 1'b1, 8'd0, 1'b0, "mrst");
        run_cycle(1'b0, 1'b0, 8'd10, 1'b0, "mrst");
        run_cycle(1'b0, 1'b0, 8'd20, 1'b0, "mrst");
        run_cycle(1'b0, 1'b0, 8'd30, 1'b0, "mrst");
        idle(3, "mrst");
        check("mrst_pre_ready", 8'(ready), 8'd1);
        rst_n = 1'b0;
        hsync = 1'b1;
        @(posedge pclk);
        #1;
        exp_q.delete();
        line_q.delete();
        last_pop = 8'd0;
        check("mrst_ready", 8'(ready), 8'd0);
        check("mrst_dout", dout, 8'd0);
        rst_n = 1'b1;
        run_cycle(1'b0, 1'b0, 8'd77, 1'b0, "mrst_post");
        run_cycle(1'b0, 1'b0, 8'd80, 1'b0, "mrst_post");
        idle(3, "mrst_post");
        drain("mrst_post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
